multi_input_debouncer: RTL and testbench
========================================

# multi_input_debouncer

Parametrised multi-channel synchroniser and debouncer for asynchronous board inputs (buttons, interlocks, external trigger/status lines). Each channel passes through a configurable synchroniser chain, then a per-channel stability counter that updates the output only after the synchronised input has held a new level for a programmable number of consecutive cycles. Registered per-channel rise/fall pulses and an any-change flag are produced for direct use by register files and interrupt logic.

## Interface
- CHANNELS, 8, number of independent input channels (≥1)
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (≥2)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the output follows (≥1)
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width, derived; never overridden
- RESET_VALUE, {CHANNELS{1'b0}}, per-channel reset level of the sync chains and outputs
- clk  input  1  clock for all logic
- res  input  1  reset, synchronous, active-high
- async_in  input  CHANNELS  asynchronous inputs
- sync_out  output  CHANNELS  debounced, synchronised levels
- rise_pulse  output  CHANNELS  one-cycle pulse when sync_out goes 0→1
- fall_pulse  output  CHANNELS  one-cycle pulse when sync_out goes 1→0
- any_change  output  1  OR of all rise_pulse and fall_pulse bits, registered alongside them
- event_flags  output  CHANNELS  sticky change flags (only with DEBOUNCE_EVENT_LATCH_EN)
- event_clr  input  CHANNELS  per-bit clear of event_flags (only with DEBOUNCE_EVENT_LATCH_EN)

## Operation
- One clock, `clk`; reset is synchronous and active-high, on `res`.
- While res=1 at a clk edge: every sync-chain stage and sync_out[i] load RESET_VALUE[i]; counters load 0; rise_pulse, fall_pulse, any_change and event_flags load 0. No edges are reported on reset exit while inputs equal RESET_VALUE.
- Per channel i, let s = last sync stage. Each edge (res=0):
  - s == sync_out[i]: cnt ← 0, no pulse.
  - s != sync_out[i] and cnt == DEBOUNCE_CYCLES-1: sync_out[i] ← s, cnt ← 0, rise_pulse[i] ← s, fall_pulse[i] ← ~s.
  - otherwise: cnt ← cnt+1.
- Pulses are 0 in every cycle not covered above; rise and fall never assert together on one channel.
- A glitch (s returning to sync_out before the count completes) clears the counter; the next disagreement restarts from 0.
- Channels are fully independent; simultaneous updates on several channels assert all their pulse bits in the same cycle and any_change once.
- DEBOUNCE_CYCLES=1: no filtering; sync_out follows s one cycle later.

## Timing
- Input change latency: a level that settles before edge k and then stays stable appears in s after edge k+SYNC_STAGES-1, and in sync_out after edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES.
- Rejected glitch width: s pulses shorter than DEBOUNCE_CYCLES cycles never reach sync_out.
- rise_pulse/fall_pulse/any_change are registered and high in exactly the cycle sync_out first shows the new level.
- Reset asserted mid-count: counter discarded; outputs at RESET_VALUE the cycle after the reset edge; debouncing restarts from 0 after release.

## Configuration
- DEBOUNCE_EVENT_LATCH_EN defined: event_flags and event_clr exist. event_flags[i] sets on rise_pulse[i] or fall_pulse[i] (in the same edge the pulse is registered) and holds until event_clr[i]=1 at an edge; set wins over a simultaneous clear. Reset clears all flags.
- Not defined: ports and flag registers are absent; all other behaviour is identical.

## Test plan
- Reset: RESET_VALUE=8'hA5, hold res 3 cycles, inputs = 8'hA5 -> sync_out=8'hA5, all pulses 0 during and after reset release.
- Clean edge: SYNC_STAGES=2, DEBOUNCE_CYCLES=16, async_in[0] 0→1 before edge k -> sync_out[0]=1 and rise_pulse[0]=1 exactly after edge k+17, pulse lasting one cycle.
- Glitch rejection: async_in[3] high for 10 cycles then low -> sync_out[3] stays 0, no pulses; then high for 20 cycles -> one rise_pulse[3].
- Simultaneous: channels 1 (rise) and 6 (fall) change on the same edge -> rise_pulse=8'h02, fall_pulse=8'h40, any_change=1 in the same cycle.
- Reset mid-count: async_in[2] high, assert res after 8 counted cycles -> sync_out[2]=RESET_VALUE[2]; after release input needs the full 2+16 cycles.
- With DEBOUNCE_EVENT_LATCH_EN: rise on channel 5 -> event_flags[5]=1 until event_clr[5] pulse; clear coincident with a new fall pulse on channel 5 -> flag remains 1.

Source files
------------

// File: rtl/multi_input_debouncer.sv
// Multi-channel input synchroniser and debouncer with registered edge pulses.
// Optional sticky per-channel event flags are built when DEBOUNCE_EVENT_LATCH_EN is defined.
module multi_input_debouncer #(
    parameter int                  CHANNELS        = 8,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                res,
    input  logic [CHANNELS-1:0] async_in,
`ifdef DEBOUNCE_EVENT_LATCH_EN
    input  logic [CHANNELS-1:0] event_clr,
    output logic [CHANNELS-1:0] event_flags,
`endif
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  sync_out_q, sync_out_d;
    logic [CHANNELS-1:0]                  rise_q, rise_d;
    logic [CHANNELS-1:0]                  fall_q, fall_d;
    logic                                 any_change_q, any_change_d;
    logic [CHANNELS-1:0]                  sync_s;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = async_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronised level disagrees with the output.
    always_comb begin
        cnt_d      = cnt_q;
        sync_out_d = sync_out_q;
        rise_d     = '0;
        fall_d     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync_s[i] == sync_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sync_out_d[i] = sync_s[i];
                cnt_d[i]      = '0;
                rise_d[i]     = sync_s[i];
                fall_d[i]     = ~sync_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        any_change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            sync_q       <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q        <= '0;
            sync_out_q   <= RESET_VALUE;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            sync_out_q   <= sync_out_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_change_q <= any_change_d;
        end
    end

    assign sync_out   = sync_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_change_q;

`ifdef DEBOUNCE_EVENT_LATCH_EN
    logic [CHANNELS-1:0] event_flags_q, event_flags_d;

    // A new edge outranks a clear arriving on the same cycle.
    always_comb begin
        event_flags_d = (event_flags_q & ~event_clr) | rise_d | fall_d;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            event_flags_q <= '0;
        end else begin
            event_flags_q <= event_flags_d;
        end
    end

    assign event_flags = event_flags_q;
`endif

endmodule

// File: tb/tb_multi_input_debouncer.sv
// Bench for multi_input_debouncer: vector table, directed corner sequences and a random run
// checked against a window-based reference model. Flag checks build with DEBOUNCE_EVENT_LATCH_EN.
module tb_multi_input_debouncer;

    localparam int          CH = 8;
    localparam int          SS = 2;
    localparam int          DC = 16;
    localparam logic [7:0]  RV = 8'hA5;

    logic       clk = 1'b0;
    logic       res;
    logic [7:0] async_in;
    logic [7:0] clr_drv;
    logic [7:0] sync_out, rise_pulse, fall_pulse;
    logic       any_change;
`ifdef DEBOUNCE_EVENT_LATCH_EN
    logic [7:0] event_flags, event_clr;
    assign event_clr = clr_drv;
`endif

    multi_input_debouncer #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .res(res), .async_in(async_in),
`ifdef DEBOUNCE_EVENT_LATCH_EN
        .event_clr(event_clr), .event_flags(event_flags),
`endif
        .sync_out(sync_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a delay line for the synchroniser and a window of the last DC
    // synchronised samples; the output takes a new level once the whole window holds it.
    logic [7:0] syncq[$];
    logic [7:0] shist[$];
    logic [7:0] exp_out, exp_rise, exp_fall, exp_flags;
    logic       exp_any;

    task automatic model_edge();
        logic [7:0] s, nxt;
        bit         all_eq;
        if (res) begin
            syncq.delete();
            for (int i = 0; i < SS; i++) syncq.push_back(RV);
            shist.delete();
            exp_out = RV; exp_rise = '0; exp_fall = '0; exp_any = 1'b0; exp_flags = '0;
        end else begin
            s = syncq.pop_front();
            syncq.push_back(async_in);
            shist.push_back(s);
            if (shist.size() > DC) void'(shist.pop_front());
            nxt = exp_out;
            if (shist.size() == DC) begin
                for (int c = 0; c < CH; c++) begin
                    all_eq = 1'b1;
                    for (int j = 0; j < DC; j++) begin
                        logic [7:0] h;
                        h = shist[j];
                        if (h[c] != s[c]) all_eq = 1'b0;
                    end
                    if (all_eq && s[c] != exp_out[c]) nxt[c] = s[c];
                end
            end
            exp_rise  = nxt & ~exp_out;
            exp_fall  = ~nxt & exp_out;
            exp_any   = |(exp_rise | exp_fall);
            exp_flags = (exp_flags & ~clr_drv) | exp_rise | exp_fall;
            exp_out   = nxt;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", {sync_out, rise_pulse, fall_pulse, 7'd0, any_change},
                     {exp_out, exp_rise, exp_fall, 7'd0, exp_any});
`ifdef DEBOUNCE_EVENT_LATCH_EN
        chk("model_flags", {24'd0, event_flags}, {24'd0, exp_flags});
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic       r;
        logic [7:0] in;
        int         reps;
        logic [7:0] eo, er, ef;
        logic       ea;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int rises;
        tbl[0] = '{1'b1, 8'hA5, 3,  8'hA5, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'hA5, 20, 8'hA5, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'hE5, 17, 8'hA5, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 8'hE5, 1,  8'hE5, 8'h40, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 8'hE5, 1,  8'hE5, 8'h00, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 8'hA7, 17, 8'hE5, 8'h00, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'hA7, 1,  8'hA7, 8'h02, 8'h40, 1'b1};
        tbl[7] = '{1'b0, 8'hA7, 1,  8'hA7, 8'h00, 8'h00, 1'b0};

        res = 1'b1; async_in = RV; clr_drv = '0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            res = tbl[v].r;
            async_in = tbl[v].in;
            steps(tbl[v].reps);
            chk($sformatf("tbl%0d", v), {sync_out, rise_pulse, fall_pulse, 7'd0, any_change},
                {tbl[v].eo, tbl[v].er, tbl[v].ef, 7'd0, tbl[v].ea});
        end

        // Clean rising edge on channel 0: visible exactly 18 edges after the input changes.
        async_in = 8'hA6;
        steps(20);
        async_in = 8'hA7;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("clean_hold", {30'd0, sync_out[0], rise_pulse[0]}, 32'd0);
        end
        step();
        chk("clean_rise", {30'd0, sync_out[0], rise_pulse[0]}, 32'd3);
        step();
        chk("clean_one_shot", {30'd0, sync_out[0], rise_pulse[0]}, 32'd2);

        // Glitch on channel 3 shorter than the debounce window.
        async_in = 8'hAF;
        steps(10);
        async_in = 8'hA7;
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rise_pulse[3] || fall_pulse[3] || sync_out[3]) rises++;
        end
        chk("glitch_reject", rises, 0);
        async_in = 8'hAF;
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rise_pulse[3]) rises++;
        end
        chk("glitch_then_rise", {rises[30:0], sync_out[3]}, {31'd1, 1'b1});

        // Reset after 8 counted cycles on channel 2; counting restarts from scratch.
        async_in = 8'hAB;
        steps(10);
        res = 1'b1;
        step();
        chk("midcount_reset", {24'd0, sync_out}, {24'd0, RV});
        res = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("midcount_hold", {30'd0, sync_out[2], fall_pulse[2]}, 32'd2);
        end
        step();
        chk("midcount_fall", {30'd0, sync_out[2], fall_pulse[2]}, 32'd1);

`ifdef DEBOUNCE_EVENT_LATCH_EN
        async_in = 8'h8B;
        steps(20);
        clr_drv = 8'hFF;
        step();
        clr_drv = 8'h00;
        chk("flags_cleared", {24'd0, event_flags}, 32'd0);
        async_in = 8'hAB;
        steps(18);
        chk("flag5_set", {31'd0, event_flags[5]}, 32'd1);
        steps(3);
        chk("flag5_sticky", {31'd0, event_flags[5]}, 32'd1);
        clr_drv = 8'h20;
        step();
        clr_drv = 8'h00;
        chk("flag5_clear", {31'd0, event_flags[5]}, 32'd0);
        async_in = 8'h8B;
        steps(17);
        clr_drv = 8'h20;
        step();
        clr_drv = 8'h00;
        chk("flag5_set_wins", {30'd0, fall_pulse[5], event_flags[5]}, 32'd3);
`endif

        // Random run: sparse bit flips give both short glitches and long stable holds.
        for (int n = 0; n < 3000; n++) begin
            res = ($urandom_range(399) == 0);
            if ($urandom_range(39) == 0) async_in = 8'($urandom);
            else if ($urandom_range(7) == 0) async_in[$urandom_range(7)] ^= 1'b1;
            clr_drv = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
